// File: rtl/wasm_alu_pkg.sv
// ============================================================================
// Module   : wasm_alu_pkg
// Contents : Op-code constants, FSM state type and WIDTH legality check
//            for the multi-cycle WebAssembly integer ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wasm_alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_SELECT = 5'd4;
    localparam logic [4:0] OP_EQZ    = 5'd5;
    localparam logic [4:0] OP_EQ     = 5'd6;
    localparam logic [4:0] OP_LT_U   = 5'd7;
    localparam logic [4:0] OP_GT_U   = 5'd8;
    localparam logic [4:0] OP_LE_U   = 5'd9;
    localparam logic [4:0] OP_GE_U   = 5'd10;
    localparam logic [4:0] OP_LT_S   = 5'd11;
    localparam logic [4:0] OP_GT_S   = 5'd12;
    localparam logic [4:0] OP_LE_S   = 5'd13;
    localparam logic [4:0] OP_GE_S   = 5'd14;
    localparam logic [4:0] OP_NE     = 5'd15;
    localparam logic [4:0] OP_SHL    = 5'd16;
    localparam logic [4:0] OP_SHR_S  = 5'd17;
    localparam logic [4:0] OP_SHR_U  = 5'd18;
    localparam logic [4:0] OP_ROTL   = 5'd19;
    localparam logic [4:0] OP_ROTR   = 5'd20;
    localparam logic [4:0] OP_MUL    = 5'd21;
    localparam logic [4:0] OP_DIV_S  = 5'd22;
    localparam logic [4:0] OP_DIV_U  = 5'd23;
    localparam logic [4:0] OP_REM_S  = 5'd24;
    localparam logic [4:0] OP_REM_U  = 5'd25;
    localparam logic [4:0] OP_CLZ    = 5'd26;
    localparam logic [4:0] OP_CTZ    = 5'd27;
    localparam logic [4:0] OP_POPCNT = 5'd28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_t;

    function automatic bit width_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wasm_alu_div.sv
// ============================================================================
// Module   : wasm_alu_div
// Contents : Iterative restoring unsigned divider, one quotient bit per cycle.
//            o_done/o_quot/o_rem present the final step combinationally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wasm_alu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CW = $clog2(WIDTH);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // Partial remainder is always below the divisor, so WIDTH+1 bits suffice.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_fits  = ~w_diff[WIDTH];

    assign o_quot  = {r_quot[WIDTH-2:0], w_fits};
    assign o_rem   = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_done  = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
        end else if (r_busy) begin
            r_quot <= o_quot;
            r_rem  <= o_rem;
            r_cnt  <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wasm_alu_mc.sv
// ============================================================================
// Module   : wasm_alu_mc
// Contents : Multi-cycle WebAssembly i32/i64 ALU with valid/ready handshake.
//            Define WASM_ALU_DIV_EN to build the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wasm_alu_mc
    import wasm_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             trap
);

    localparam int SHW = $clog2(WIDTH);

    generate
        if (!width_legal(WIDTH)) begin : g_width_illegal
            $error("wasm_alu_mc: WIDTH must be 32 or 64");
        end
    endgenerate

    alu_state_t       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_trap;

    logic             w_accept;
    logic             w_go_busy;
    logic [WIDTH-1:0] w_res;
    logic             w_trap;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_res;
    logic [SHW-1:0]   w_sh;
    logic [SHW-1:0]   w_sh_neg;

    function automatic logic [WIDTH-1:0] f_bool(input logic v);
        return {{(WIDTH-1){1'b0}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] f_clz(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        logic             seen;
        n    = '0;
        seen = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i])       seen = 1'b1;
            else if (!seen) n    = n + WIDTH'(1);
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] f_ctz(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        logic             seen;
        n    = '0;
        seen = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i])       seen = 1'b1;
            else if (!seen) n    = n + WIDTH'(1);
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] f_popcnt(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + WIDTH'(v[i]);
        return n;
    endfunction

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign trap      = r_trap;

    // Rotating by -sh in the opposite direction makes rotate-by-0 return b.
    assign w_sh      = a[SHW-1:0];
    assign w_sh_neg  = -w_sh;

`ifdef WASM_ALU_DIV_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;
    logic             w_signed;
    logic             w_ovf;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_signed  = (op == OP_DIV_S) || (op == OP_REM_S);
    assign w_ovf     = (b == {1'b1, {(WIDTH-1){1'b0}}}) && (a == '1);
    assign w_mag_a   = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_mag_b   = (w_signed && b[WIDTH-1]) ? -b : b;
    assign w_div_res = r_is_rem ? (r_neg_r ? -w_rem  : w_rem)
                                : (r_neg_q ? -w_quot : w_quot);

    wasm_alu_div #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_accept && w_go_busy),
        .i_dividend (w_mag_b),
        .i_divisor  (w_mag_a),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (w_accept) begin
            r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= w_signed && b[WIDTH-1];
            r_is_rem <= (op == OP_REM_S) || (op == OP_REM_U);
        end
    end
`else
    assign w_div_done = 1'b0;
    assign w_div_res  = '0;
`endif

    always_comb begin
        w_res     = '0;
        w_trap    = 1'b0;
        w_go_busy = 1'b0;
        case (op)
            OP_ADD:    w_res = b + a;
            OP_SUB:    w_res = b - a;
            OP_AND:    w_res = b & a;
            OP_OR:     w_res = b | a;
            OP_SELECT: w_res = (a == '0) ? b : c;
            OP_EQZ:    w_res = f_bool(a == '0);
            OP_EQ:     w_res = f_bool(b == a);
            OP_LT_U:   w_res = f_bool(b < a);
            OP_GT_U:   w_res = f_bool(b > a);
            OP_LE_U:   w_res = f_bool(b <= a);
            OP_GE_U:   w_res = f_bool(b >= a);
            OP_LT_S:   w_res = f_bool($signed(b) <  $signed(a));
            OP_GT_S:   w_res = f_bool($signed(b) >  $signed(a));
            OP_LE_S:   w_res = f_bool($signed(b) <= $signed(a));
            OP_GE_S:   w_res = f_bool($signed(b) >= $signed(a));
            OP_NE:     w_res = f_bool(b != a);
            OP_SHL:    w_res = b << w_sh;
            OP_SHR_S:  w_res = $signed(b) >>> w_sh;
            OP_SHR_U:  w_res = b >> w_sh;
            OP_ROTL:   w_res = (b << w_sh) | (b >> w_sh_neg);
            OP_ROTR:   w_res = (b >> w_sh) | (b << w_sh_neg);
            OP_MUL:    w_res = b * a;
            OP_DIV_S, OP_DIV_U, OP_REM_S, OP_REM_U: begin
`ifdef WASM_ALU_DIV_EN
                if (a == '0) begin
                    w_trap = 1'b1;
                end else if (w_ovf && (op == OP_DIV_S)) begin
                    w_trap = 1'b1;
                end else if (!(w_ovf && (op == OP_REM_S))) begin
                    w_go_busy = 1'b1;
                end
`else
                w_trap = 1'b1;
`endif
            end
            OP_CLZ:    w_res = f_clz(a);
            OP_CTZ:    w_res = f_ctz(a);
            OP_POPCNT: w_res = f_popcnt(a);
            default:   w_trap = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_trap      <= 1'b0;
        end else begin
            case (r_state)
                ST_BUSY: begin
                    if (w_div_done) begin
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                        r_result    <= w_div_res;
                        r_trap      <= 1'b0;
                    end
                end
                default: begin
                    if ((r_state == ST_HOLD) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (w_go_busy) begin
                            r_state     <= ST_BUSY;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_HOLD;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_trap      <= w_trap;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wasm_alu_mc.sv
// ============================================================================
// Module   : tb_wasm_alu_mc
// Contents : Directed self-checking bench for wasm_alu_mc (32- and 64-bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wasm_alu_mc;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] res;
        logic        trp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv32 = 1'b0, ir32, ov32, ordy32 = 1'b0, tr32;
    logic [4:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0, c32 = '0, res32;

    logic        iv64 = 1'b0, ir64, ov64, ordy64 = 1'b0, tr64;
    logic [4:0]  op64 = '0;
    logic [63:0] a64 = '0, b64 = '0, c64 = '0, res64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wasm_alu_mc #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .a(a32), .b(b32), .c(c32), .out_valid(ov32), .out_ready(ordy32),
        .result(res32), .trap(tr32)
    );

    wasm_alu_mc #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .op(op64),
        .a(a64), .b(b64), .c(c64), .out_valid(ov64), .out_ready(ordy64),
        .result(res64), .trap(tr64)
    );

    // Issue one op on an idle DUT, wait (bounded) for out_valid, then drain it.
    task automatic run32(input logic [4:0] op, input logic [31:0] a, b, c,
                         output int lat, output logic [31:0] res, output logic trp);
        op32 = op; a32 = a; b32 = b; c32 = c; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat  = 1;
        while (!ov32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov32) lat = -1;
        res = res32; trp = tr32;
        ordy32 = 1'b1;
        @(posedge clk); #1;
        ordy32 = 1'b0;
    endtask

    task automatic run64(input logic [4:0] op, input logic [63:0] a, b, c,
                         output int lat, output logic [63:0] res, output logic trp);
        op64 = op; a64 = a; b64 = b; c64 = c; iv64 = 1'b1;
        @(posedge clk); #1;
        iv64 = 1'b0;
        lat  = 1;
        while (!ov64 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov64) lat = -1;
        res = res64; trp = tr64;
        ordy64 = 1'b1;
        @(posedge clk); #1;
        ordy64 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (ov32 !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got %b exp 0", ov32); end
        if (res32 !== '0)   begin failures++; $display("FAIL reset_result got %h exp 0", res32); end
        if (tr32 !== 1'b0)  begin failures++; $display("FAIL reset_trap got %b exp 0", tr32); end
        if (ov64 !== 1'b0)  begin failures++; $display("FAIL reset_out_valid64 got %b exp 0", ov64); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (ir32 !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got %b exp 1", ir32); end
        if (ir64 !== 1'b1)  begin failures++; $display("FAIL reset_in_ready64 got %b exp 1", ir64); end
    endtask

    task automatic check_table32(input string name, input vec_t q[$]);
        int lat; logic [31:0] res; logic trp;
        foreach (q[i]) begin
            run32(q[i].op, q[i].a[31:0], q[i].b[31:0], q[i].c[31:0], lat, res, trp);
            checks += 3;
            if (res !== q[i].res[31:0]) begin failures++;
                $display("FAIL %s[%0d] op=%0d result got %h exp %h", name, i, q[i].op, res, q[i].res[31:0]); end
            if (trp !== q[i].trp) begin failures++;
                $display("FAIL %s[%0d] op=%0d trap got %b exp %b", name, i, q[i].op, trp, q[i].trp); end
            if (lat != q[i].lat) begin failures++;
                $display("FAIL %s[%0d] op=%0d latency got %0d exp %0d", name, i, q[i].op, lat, q[i].lat); end
        end
    endtask

    task automatic test_arith;
        vec_t q[$];
        q.push_back('{5'd0,  64'd7,         64'd5,         64'd0,  64'd12,        1'b0, 1});
        q.push_back('{5'd1,  64'd7,         64'd5,         64'd0,  64'hFFFFFFFE,  1'b0, 1});
        q.push_back('{5'd2,  64'hF0F0,      64'hFF00,      64'd0,  64'hF000,      1'b0, 1});
        q.push_back('{5'd3,  64'hF0F0,      64'h0F0F,      64'd0,  64'hFFFF,      1'b0, 1});
        q.push_back('{5'd4,  64'd0,         64'd11,        64'd22, 64'd11,        1'b0, 1});
        q.push_back('{5'd4,  64'd1,         64'd11,        64'd22, 64'd22,        1'b0, 1});
        q.push_back('{5'd5,  64'd0,         64'd0,         64'd0,  64'd1,         1'b0, 1});
        q.push_back('{5'd5,  64'd5,         64'd0,         64'd0,  64'd0,         1'b0, 1});
        q.push_back('{5'd6,  64'd9,         64'd9,         64'd0,  64'd1,         1'b0, 1});
        q.push_back('{5'd7,  64'd1,         64'hFFFFFFFF,  64'd0,  64'd0,         1'b0, 1});
        q.push_back('{5'd8,  64'd1,         64'hFFFFFFFF,  64'd0,  64'd1,         1'b0, 1});
        q.push_back('{5'd9,  64'd4,         64'd4,         64'd0,  64'd1,         1'b0, 1});
        q.push_back('{5'd10, 64'd5,         64'd4,         64'd0,  64'd0,         1'b0, 1});
        q.push_back('{5'd11, 64'd1,         64'hFFFFFFFF,  64'd0,  64'd1,         1'b0, 1});
        q.push_back('{5'd12, 64'd3,         64'd3,         64'd0,  64'd0,         1'b0, 1});
        q.push_back('{5'd13, 64'hFFFFFFFF,  64'd0,         64'd0,  64'd0,         1'b0, 1});
        q.push_back('{5'd14, 64'hFFFFFFFE,  64'hFFFFFFFE,  64'd0,  64'd1,         1'b0, 1});
        q.push_back('{5'd15, 64'd5,         64'd4,         64'd0,  64'd1,         1'b0, 1});
        q.push_back('{5'd16, 64'd33,        64'd1,         64'd0,  64'd2,         1'b0, 1});
        q.push_back('{5'd17, 64'd4,         64'h80000000,  64'd0,  64'hF8000000,  1'b0, 1});
        q.push_back('{5'd18, 64'd4,         64'h80000000,  64'd0,  64'h08000000,  1'b0, 1});
        q.push_back('{5'd19, 64'd0,         64'h80000001,  64'd0,  64'h80000001,  1'b0, 1});
        q.push_back('{5'd19, 64'd4,         64'h80000001,  64'd0,  64'h00000018,  1'b0, 1});
        q.push_back('{5'd20, 64'd1,         64'd1,         64'd0,  64'h80000000,  1'b0, 1});
        q.push_back('{5'd21, 64'h10000,     64'h10000,     64'd0,  64'd0,         1'b0, 1});
        q.push_back('{5'd21, 64'd6,         64'd7,         64'd0,  64'd42,        1'b0, 1});
        q.push_back('{5'd21, 64'hFFFFFFFF,  64'd3,         64'd0,  64'hFFFFFFFD,  1'b0, 1});
        q.push_back('{5'd26, 64'd0,         64'd0,         64'd0,  64'd32,        1'b0, 1});
        q.push_back('{5'd26, 64'd1,         64'd0,         64'd0,  64'd31,        1'b0, 1});
        q.push_back('{5'd27, 64'd8,         64'd0,         64'd0,  64'd3,         1'b0, 1});
        q.push_back('{5'd27, 64'd0,         64'd0,         64'd0,  64'd32,        1'b0, 1});
        q.push_back('{5'd28, 64'hF0F0,      64'd0,         64'd0,  64'd8,         1'b0, 1});
        q.push_back('{5'd29, 64'd1,         64'd2,         64'd0,  64'd0,         1'b1, 1});
        q.push_back('{5'd31, 64'd1,         64'd2,         64'd0,  64'd0,         1'b1, 1});
        check_table32("arith", q);
    endtask

    task automatic test_div;
        vec_t q[$];
`ifdef WASM_ALU_DIV_EN
        q.push_back('{5'd22, 64'd2,         64'hFFFFFFF9,  64'd0,  64'hFFFFFFFD,  1'b0, 33});
        q.push_back('{5'd24, 64'd2,         64'hFFFFFFF9,  64'd0,  64'hFFFFFFFF,  1'b0, 33});
        q.push_back('{5'd23, 64'd7,         64'd100,       64'd0,  64'd14,        1'b0, 33});
        q.push_back('{5'd25, 64'd7,         64'd100,       64'd0,  64'd2,         1'b0, 33});
        q.push_back('{5'd22, 64'hFFFFFFFD,  64'd7,         64'd0,  64'hFFFFFFFE,  1'b0, 33});
        q.push_back('{5'd24, 64'hFFFFFFFD,  64'd7,         64'd0,  64'd1,         1'b0, 33});
        q.push_back('{5'd23, 64'd2,         64'hFFFFFFFF,  64'd0,  64'h7FFFFFFF,  1'b0, 33});
        q.push_back('{5'd22, 64'd1,         64'h80000000,  64'd0,  64'h80000000,  1'b0, 33});
        q.push_back('{5'd23, 64'd0,         64'd9,         64'd0,  64'd0,         1'b1, 1});
        q.push_back('{5'd22, 64'hFFFFFFFF,  64'h80000000,  64'd0,  64'd0,         1'b1, 1});
        q.push_back('{5'd24, 64'hFFFFFFFF,  64'h80000000,  64'd0,  64'd0,         1'b0, 1});
        q.push_back('{5'd25, 64'd0,         64'd5,         64'd0,  64'd0,         1'b1, 1});
`else
        q.push_back('{5'd22, 64'd2,         64'hFFFFFFF9,  64'd0,  64'd0,         1'b1, 1});
        q.push_back('{5'd23, 64'd7,         64'd100,       64'd0,  64'd0,         1'b1, 1});
        q.push_back('{5'd24, 64'd2,         64'hFFFFFFF9,  64'd0,  64'd0,         1'b1, 1});
        q.push_back('{5'd25, 64'd7,         64'd100,       64'd0,  64'd0,         1'b1, 1});
        q.push_back('{5'd23, 64'd0,         64'd9,         64'd0,  64'd0,         1'b1, 1});
`endif
        check_table32("div", q);
    endtask

    task automatic test_w64;
        vec_t q[$];
        int lat; logic [63:0] res; logic trp;
        q.push_back('{5'd19, 64'd65, 64'h8000000000000001, 64'd0, 64'h3, 1'b0, 1});
        q.push_back('{5'd26, 64'd0,  64'd0, 64'd0, 64'd64, 1'b0, 1});
        q.push_back('{5'd27, 64'd0,  64'd0, 64'd0, 64'd64, 1'b0, 1});
        q.push_back('{5'd16, 64'd63, 64'd1, 64'd0, 64'h8000000000000000, 1'b0, 1});
        q.push_back('{5'd1,  64'd1,  64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1});
        q.push_back('{5'd28, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 64'd64, 1'b0, 1});
        q.push_back('{5'd17, 64'd60, 64'h8000000000000000, 64'd0, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1});
`ifdef WASM_ALU_DIV_EN
        q.push_back('{5'd23, 64'd3,  64'd100, 64'd0, 64'd33, 1'b0, 65});
`else
        q.push_back('{5'd23, 64'd3,  64'd100, 64'd0, 64'd0,  1'b1, 1});
`endif
        foreach (q[i]) begin
            run64(q[i].op, q[i].a, q[i].b, q[i].c, lat, res, trp);
            checks += 3;
            if (res !== q[i].res) begin failures++;
                $display("FAIL w64[%0d] op=%0d result got %h exp %h", i, q[i].op, res, q[i].res); end
            if (trp !== q[i].trp) begin failures++;
                $display("FAIL w64[%0d] op=%0d trap got %b exp %b", i, q[i].op, trp, q[i].trp); end
            if (lat != q[i].lat) begin failures++;
                $display("FAIL w64[%0d] op=%0d latency got %0d exp %0d", i, q[i].op, lat, q[i].lat); end
        end
    endtask

    task automatic test_back_to_back;
        ordy32 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op32 = 5'd0; a32 = 32'(i); b32 = 32'd100; iv32 = 1'b1;
            @(posedge clk); #1;
            checks += 2;
            if (ov32 !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, ov32); end
            if (res32 !== 32'(100 + i)) begin failures++;
                $display("FAIL b2b_result[%0d] got %h exp %h", i, res32, 32'(100 + i)); end
        end
        iv32 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ov32 !== 1'b0) begin failures++; $display("FAIL b2b_drain got %b exp 0", ov32); end

        ordy32 = 1'b0;
        op32 = 5'd0; a32 = 32'd1; b32 = 32'd2; iv32 = 1'b1;
        @(posedge clk); #1;
        a32 = 32'd10; b32 = 32'd20;
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (ov32 !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got %b exp 1", k, ov32); end
            if (res32 !== 32'd3) begin failures++; $display("FAIL stall_result[%0d] got %h exp 3", k, res32); end
            if (ir32 !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got %b exp 0", k, ir32); end
            @(posedge clk); #1;
        end
        ordy32 = 1'b1;
        #1;
        checks++;
        if (ir32 !== 1'b1) begin failures++; $display("FAIL release_in_ready got %b exp 1", ir32); end
        @(posedge clk); #1;
        iv32 = 1'b0;
        checks += 2;
        if (ov32 !== 1'b1) begin failures++; $display("FAIL release_valid got %b exp 1", ov32); end
        if (res32 !== 32'd30) begin failures++; $display("FAIL release_result got %h exp 1e", res32); end
        @(posedge clk); #1;
        ordy32 = 1'b0;
    endtask

    task automatic test_reset_busy;
        int lat; logic [31:0] res; logic trp; logic seen;
`ifdef WASM_ALU_DIV_EN
        op32 = 5'd23; a32 = 32'd7; b32 = 32'd100; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov32 !== 1'b0) begin failures++; $display("FAIL abort_valid_in_reset got %b exp 0", ov32); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ov32) seen = 1'b1;
        end
        checks += 2;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_result_leak got %b exp 0", seen); end
        if (ir32 !== 1'b1) begin failures++; $display("FAIL abort_in_ready got %b exp 1", ir32); end
`else
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = ov32;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_valid got %b exp 0", seen); end
`endif
        run32(5'd0, 32'd3, 32'd2, 32'd0, lat, res, trp);
        checks += 3;
        if (res !== 32'd5) begin failures++; $display("FAIL post_reset_add got %h exp 5", res); end
        if (trp !== 1'b0)  begin failures++; $display("FAIL post_reset_trap got %b exp 0", trp); end
        if (lat != 1)      begin failures++; $display("FAIL post_reset_latency got %0d exp 1", lat); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arith();
        test_div();
        test_w64();
        test_back_to_back();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
